// File: rtl/complementador_a_2_serial.sv
// Bit-serial two's/one's complementer: latches an operand on inicio, walks it LSB-first
// with the copy-through-first-one-then-invert rule, and presents the parallel result at the end.
module complementador_a_2_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic             modo,
  input  logic [WIDTH-1:0] entrada,
  output logic             listo,
  output logic             bit_serie,
  output logic             bit_valido,
  output logic [WIDTH-1:0] salida,
  output logic             hecho,
  output logic             desborde
);

  localparam int unsigned KW = $clog2(WIDTH);
  localparam logic [KW-1:0] KLast = KW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StReposo, StDesplaza, StFin} state_e;

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] operando_q;
  logic [WIDTH-2:0] res_q;
  logic             modo_q;
  logic             visto_uno_q;

  logic             bit_in;
  logic             bit_calc;
  logic [WIDTH-1:0] res_d;

  // Outputs are decoded purely from registered state; no input reaches them combinationally.
  always_comb begin
    bit_in     = operando_q[k_q];
    bit_calc   = (modo_q || visto_uno_q) ? ~bit_in : bit_in;
    res_d      = {bit_calc, res_q};
    listo      = (state_q == StReposo);
    bit_valido = (state_q == StDesplaza);
    hecho      = (state_q == StFin);
    bit_serie  = bit_valido & bit_calc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StReposo;
      k_q         <= '0;
      operando_q  <= '0;
      res_q       <= '0;
      modo_q      <= 1'b0;
      visto_uno_q <= 1'b0;
      salida      <= '0;
      desborde    <= 1'b0;
    end else begin
      unique case (state_q)
        StReposo: begin
          if (inicio) begin
            operando_q  <= entrada;
            modo_q      <= modo;
            visto_uno_q <= 1'b0;
            k_q         <= '0;
            state_q     <= StDesplaza;
          end
        end
        StDesplaza: begin
          // Result bits shift in from the top so bit k lands at position k after WIDTH steps.
          res_q       <= res_d[WIDTH-1:1];
          visto_uno_q <= visto_uno_q | bit_in;
          if (k_q == KLast) begin
            salida   <= res_d;
            desborde <= ~modo_q && (operando_q == MinNeg);
            state_q  <= StFin;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        StFin: begin
          state_q <= StReposo;
        end
        default: begin
          state_q <= StReposo;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complementador_a_2_serial.sv
// Directed bench for complementador_a_2_serial: WIDTH=8 timing/handshake cases and
// an exhaustive-plus-random WIDTH=4 arithmetic sweep.
module tb_complementador_a_2_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       inicio8, modo8, inicio4, modo4;
  logic [7:0] ent8, sal8;
  logic [3:0] ent4, sal4;
  logic       listo8, bs8, bv8, hecho8, desb8;
  logic       listo4, bs4, bv4, hecho4, desb4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  complementador_a_2_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .inicio(inicio8), .modo(modo8), .entrada(ent8),
    .listo(listo8), .bit_serie(bs8), .bit_valido(bv8), .salida(sal8),
    .hecho(hecho8), .desborde(desb8)
  );

  complementador_a_2_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .inicio(inicio4), .modo(modo4), .entrada(ent4),
    .listo(listo4), .bit_serie(bs4), .bit_valido(bv4), .salida(sal4),
    .hecho(hecho4), .desborde(desb4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] neg8(input logic [7:0] x);
    neg8 = ~x + 8'd1;
  endfunction

  // Full WIDTH=8 operation with cycle-exact checks of the serial stream and completion.
  task automatic run_op8(input logic m, input logic [7:0] x);
    logic [7:0] exp;
    exp = m ? ~x : neg8(x);
    @(negedge clk);
    check("listo8_pre", listo8, 1);
    inicio8 = 1'b1; modo8 = m; ent8 = x;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        inicio8 = 1'b0; modo8 = ~m; ent8 = ~x;
      end
      check("bv8", bv8, 1);
      check("bs8", bs8, exp[k]);
      check("hecho8_busy", hecho8, 0);
      check("listo8_busy", listo8, 0);
    end
    @(negedge clk);
    check("hecho8", hecho8, 1);
    check("salida8", sal8, exp);
    check("desb8", desb8, (!m && x == 8'h80));
    check("bv8_fin", bv8, 0);
    check("bs8_fin", bs8, 0);
    @(negedge clk);
    check("hecho8_once", hecho8, 0);
    check("listo8_post", listo8, 1);
    check("salida8_hold", sal8, exp);
  endtask

  task automatic run_op4(input logic m, input logic [3:0] x);
    logic [3:0] exp;
    exp = m ? ~x : (~x + 4'd1);
    @(negedge clk);
    inicio4 = 1'b1; modo4 = m; ent4 = x;
    @(posedge clk);
    @(negedge clk);
    inicio4 = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("hecho4", hecho4, 1);
    check("salida4", sal4, exp);
    check("desb4", desb4, (!m && x == 4'b1000));
    @(negedge clk);
    check("listo4", listo4, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] lat [3];
    logic [7:0] v;
    rst = 1'b1;
    inicio8 = 1'b0; modo8 = 1'b0; ent8 = '0;
    inicio4 = 1'b0; modo4 = 1'b0; ent4 = '0;
    repeat (2) @(negedge clk);
    check("rst_listo", listo8, 1);
    check("rst_bs", bs8, 0);
    check("rst_bv", bv8, 0);
    check("rst_salida", sal8, 0);
    check("rst_hecho", hecho8, 0);
    check("rst_desb", desb8, 0);
    rst = 1'b0;

    run_op8(1'b0, 8'h01);
    run_op8(1'b0, 8'h80);
    run_op8(1'b0, 8'h00);
    run_op8(1'b1, 8'h5A);
    run_op8(1'b0, 8'h6C);

    // inicio held high: one latch every 10 cycles, each on the operand present that cycle.
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check("hold_listo", listo8, (c % 10 == 0));
      check("hold_hecho", hecho8, (c % 10 == 9));
      if (c % 10 == 9) check("hold_salida", sal8, neg8(lat[c / 10]));
      v = 8'(c * 23 + 7);
      inicio8 = 1'b1; modo8 = 1'b0; ent8 = v;
      if (c % 10 == 0) lat[c / 10] = v;
    end
    @(negedge clk);
    inicio8 = 1'b0;
    check("hold_end_listo", listo8, 1);

    // Reset in cycle 4 of an operation.
    inicio8 = 1'b1; modo8 = 1'b0; ent8 = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    inicio8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_listo", listo8, 1);
    check("midrst_bv", bv8, 0);
    check("midrst_bs", bs8, 0);
    check("midrst_salida", sal8, 0);
    check("midrst_hecho", hecho8, 0);
    rst = 1'b0;
    run_op8(1'b0, 8'h3C);

    for (int i = 0; i < 16; i++) begin
      run_op4(1'b0, 4'(i));
      run_op4(1'b1, 4'(i));
    end
    for (int i = 0; i < 30; i++) begin
      run_op4(1'($urandom_range(1)), 4'($urandom_range(15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
